// File: rtl/mc6850_fifo_acia_if.sv
// CPU-side bus bundle for the 6850-style ACIA.
// Two ports: addr 0 is status/control, addr 1 is data.
interface mc6850_fifo_acia_if;
  logic       addr;
  logic [7:0] data_in;
  logic       rd;
  logic       we;
  logic       ce;
  logic [7:0] data_out;

  modport master (
    output addr, data_in, rd, we, ce,
    input  data_out
  );

  modport slave (
    input  addr, data_in, rd, we, ce,
    output data_out
  );
endinterface

// File: rtl/mc6850_fifo_acia.sv
// 6850-style ACIA with built-in UART engine, RX FIFO,
// TX holding register, framing/overrun flags and irq_n.
module mc6850_fifo_acia #(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 115200,
  parameter int RX_DEPTH   = 16,
  parameter bit STRIP_BIT7 = 1'b1
) (
  input  logic                clk,
  input  logic                resetn,
  mc6850_fifo_acia_if.slave   bus,
  input  logic                rx,
  output logic                tx,
  output logic                irq_n
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(RX_DEPTH);
  localparam logic [CW-1:0] CLAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CHALF = CW'(DIV / 2 - 1);
  localparam logic [7:0] MASK = STRIP_BIT7 ? 8'h7f : 8'hff;
  localparam logic [AW:0] FULLN = (AW + 1)'(RX_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} st_t;

  logic rd_q, we_q, mr;
  assign rd_q = bus.rd & bus.ce;
  assign we_q = bus.we & bus.ce;
  assign mr   = we_q & ~bus.addr & (bus.data_in[1:0] == 2'b11);

  logic [7:0] ctrl;
  logic       ovrn, tdre;
  logic       rie, tie;
  assign rie = ctrl[7];
  assign tie = (ctrl[6:5] == 2'b01);

  logic [8:0]  mem [RX_DEPTH];
  logic [AW:0] wptr, rptr, fill;
  logic [8:0]  head, rx_word;
  logic        empty, full, pop, push, push_ok;

  assign fill    = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (fill == FULLN);
  assign head    = mem[rptr[AW-1:0]];
  assign pop     = rd_q & bus.addr & ~empty;
  assign push_ok = push & (~full | pop);

  logic [7:0] status;
  assign status = {~irq_n, 1'b0, ovrn, ~empty & head[8],
                   2'b00, tdre, ~empty};

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= rx_word;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
      ovrn <= 1'b0;
    end else if (mr) begin
      wptr <= '0;
      rptr <= '0;
      ovrn <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (rd_q & bus.addr)
        ovrn <= 1'b0;
      else if (push & full & ~pop)
        ovrn <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl         <= 8'h00;
      bus.data_out <= 8'h00;
      irq_n        <= 1'b1;
    end else begin
      if (we_q & ~bus.addr) ctrl <= bus.data_in;
      if (rd_q)
        bus.data_out <= bus.addr ?
          (empty ? 8'h00 : head[7:0] & MASK) : status;
      irq_n <= ~((rie & (~empty | ovrn)) | (tie & tdre));
    end
  end

  st_t           tx_st;
  logic [7:0]    hold, tsh;
  logic [CW-1:0] tcnt;
  logic [2:0]    tbit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_st <= IDLE;
      tx    <= 1'b1;
      tdre  <= 1'b1;
      hold  <= 8'h00;
      tsh   <= 8'h00;
      tcnt  <= '0;
      tbit  <= '0;
    end else if (mr) begin
      tx_st <= IDLE;
      tx    <= 1'b1;
      tdre  <= 1'b1;
      tcnt  <= '0;
    end else begin
      if (we_q & bus.addr & tdre) begin
        hold <= bus.data_in & MASK;
        tdre <= 1'b0;
      end
      unique case (tx_st)
        IDLE: if (!tdre) begin
          tsh   <= hold;
          tdre  <= 1'b1;
          tx    <= 1'b0;
          tcnt  <= '0;
          tx_st <= START;
        end
        START: if (tcnt == CLAST) begin
          tcnt  <= '0;
          tbit  <= '0;
          tx    <= tsh[0];
          tx_st <= DATA;
        end else tcnt <= tcnt + 1'b1;
        DATA: if (tcnt == CLAST) begin
          tcnt <= '0;
          if (tbit == 3'd7) begin
            tx    <= 1'b1;
            tx_st <= STOP;
          end else begin
            tbit <= tbit + 1'b1;
            tsh  <= tsh >> 1;
            tx   <= tsh[1];
          end
        end else tcnt <= tcnt + 1'b1;
        STOP: if (tcnt == CLAST) begin
          tcnt <= '0;
          // chain straight into the next frame, no idle gap
          if (!tdre) begin
            tsh   <= hold;
            tdre  <= 1'b1;
            tx    <= 1'b0;
            tx_st <= START;
          end else tx_st <= IDLE;
        end else tcnt <= tcnt + 1'b1;
      endcase
    end
  end

  st_t           rx_st;
  logic          rs1, rs2, rs3;
  logic [7:0]    rsh;
  logic [CW-1:0] rcnt;
  logic [2:0]    rbit;

  assign push    = (rx_st == STOP) & (rcnt == CLAST);
  assign rx_word = {~rs2, rsh};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rs1   <= 1'b1;
      rs2   <= 1'b1;
      rs3   <= 1'b1;
      rx_st <= IDLE;
      rsh   <= 8'h00;
      rcnt  <= '0;
      rbit  <= '0;
    end else begin
      rs1 <= rx;
      rs2 <= rs1;
      rs3 <= rs2;
      if (mr) begin
        rx_st <= IDLE;
        rcnt  <= '0;
      end else begin
        unique case (rx_st)
          IDLE: if (rs3 & ~rs2) begin
            rcnt  <= '0;
            rx_st <= START;
          end
          START: if (rcnt == CHALF) begin
            rcnt  <= '0;
            rbit  <= '0;
            rx_st <= rs2 ? IDLE : DATA;
          end else rcnt <= rcnt + 1'b1;
          DATA: if (rcnt == CLAST) begin
            rcnt <= '0;
            rsh  <= {rs2, rsh[7:1]};
            if (rbit == 3'd7) rx_st <= STOP;
            else rbit <= rbit + 1'b1;
          end else rcnt <= rcnt + 1'b1;
          STOP: if (rcnt == CLAST) begin
            rcnt  <= '0;
            rx_st <= IDLE;
          end else rcnt <= rcnt + 1'b1;
        endcase
      end
    end
  end

endmodule

// File: doc/mc6850_fifo_acia.md
Name: mc6850_fifo_acia

Overview:
Parametrised 6850-style ACIA for the Altair CPU bus, with its own UART engine instead of an external UART core. Adds a configurable-depth RX FIFO, a transmit holding register, framing and overrun detection, a writable control register with master reset, and an active-low interrupt output. Sits on the CPU I/O bus at two consecutive ports (status/control, data).

Parameters:
CLK_HZ, 25000000, system clock frequency in Hz
BAUD, 115200, line rate; bit period DIV = CLK_HZ/BAUD, truncated integer, must be >= 4
RX_DEPTH, 16, RX FIFO entries; power of two, >= 2
STRIP_BIT7, 1, when 1, TX data and RX data are ANDed with 8'h7f

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
addr  in  1  0 = status/control, 1 = data
data_in  in  8  CPU write data
rd  in  1  read strobe, one cycle per access
we  in  1  write strobe, one cycle per access
ce  in  1  chip enable; rd and we are ignored unless ce=1
data_out  out  8  registered read data
rx  in  1  serial input, asynchronous, idle high
tx  out  1  serial output, idle high
irq_n  out  1  active-low interrupt request

Behaviour:
- Reset values: tx=1, data_out=8'h00, irq_n=1, control register=8'h00, FIFO empty, OVRN=0, TDRE=1, RX/TX state machines idle.
- Access qualifiers: rd_q = rd&ce, we_q = we&ce. rd_q and we_q together is undefined; the bench never drives it.
- Read latency: data_out updates on the clk edge where rd_q=1 and holds its value otherwise.
- Status word (addr0 read), bits 7..0: IRQ, PE=0, OVRN, FE, CTS=0, DCD=0, TDRE, RDRF.
  - RDRF = FIFO not empty.
  - FE = framing flag of the FIFO head entry; 0 when the FIFO is empty.
- Control register (addr0 write), stored in full:
  - bits1:0 = 2'b11 is master reset: same cycle flush FIFO, clear OVRN, abort TX (tx=1, TDRE=1, holding register empty), force RX to IDLE.
  - RIE = bit7. TIE = (bits6:5 == 2'b01).
- Data read (addr1): data_out = head byte (masked per STRIP_BIT7), then pop and clear OVRN.
  - Empty FIFO: data_out = 8'h00, no pop, OVRN still cleared.
- Data write (addr1): if TDRE=1, load the holding register and set TDRE=0. If TDRE=0, drop the write silently.
- FIFO: RX_DEPTH x 9 bits (8 data + FE). Pointers are log2(RX_DEPTH)+1 bits and wrap naturally.
  - Push when full with no pop in the same cycle: discard the character and set OVRN.
  - Push and pop in the same cycle: both take effect, including when full; no overrun in that case.
- TX engine, states IDLE, START, DATA, STOP:
  - IDLE with holding register full: next cycle copy holding to shifter, set TDRE=1, enter START.
  - Each state lasts DIV cycles. START drives tx=0. DATA sends 8 bits LSB first. STOP drives tx=1.
  - After STOP, go to IDLE, or go directly to START if the holding register is full. Back-to-back frames have no idle gap.
- RX engine, states IDLE, START, DATA, STOP:
  - rx passes through a 2-flop synchronizer. In IDLE, a synchronized falling edge enters START.
  - START: wait DIV/2 cycles, then sample. If high, it is a false start: return to IDLE with no push.
  - DATA: sample 8 bits at DIV intervals, LSB first.
  - STOP: sample after DIV cycles. FE = ~sample. Push {FE, byte} and return to IDLE, in the same cycle. A character with FE=1 is still pushed.
- irq_n = ~((RIE & (RDRF | OVRN)) | (TIE & TDRE)). This is registered, so it lags the flags by one cycle. Status bit7 is the inverse of irq_n.
- Asynchronous reset mid-frame: tx=1 immediately, and the partial RX character is lost.

Test Plan:
- CLK_HZ=1000000, BAUD=100000 (DIV=10). Write 8'hC1 to addr1 -> tx carries start, bits of 8'h41 LSB first (1,0,0,0,0,0,1,0), then stop, each exactly 10 cycles. TDRE reads 1 within 2 cycles of the write.
- Write 8'h55 then 8'hAA while TDRE=0 -> second write dropped, one frame only. Write a second byte after TDRE returns to 1 -> the two frames abut with no idle cycles.
- Drive RX frames 8'h31, 8'h32 -> status reads 8'h03. Data reads return 8'h31, then 8'h32, then 8'h00. Status then reads 8'h02.
- RX_DEPTH=4. Send 5 characters without reading -> status bit5 set, first 4 bytes read back in order, OVRN cleared after the first data read.
- Frame with stop bit held low carrying 8'h20 -> status 8'h13 (FE, TDRE, RDRF). Data read returns 8'h20. A 3-cycle low glitch on rx -> no push.
- Control 8'h80, then receive a character -> irq_n low. Read data -> irq_n high one cycle after. Control 8'h03 mid-TX -> tx=1 next cycle, status reads 8'h02.
